// File: rtl/usb_tx_flex_counter_v2.sv
// Multi-mode up/down counter with programmable step, load and reload values,
// wrap/saturate/one-shot terminal handling; every output is a flop.
module usb_tx_flex_counter_v2 #(
    parameter int SIZE   = 8,
    parameter int STEP_W = 4,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              load,
    input  logic [SIZE-1:0]   load_val,
    input  logic              count_enable,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [SIZE-1:0]   rollover_val,
    input  logic [SIZE-1:0]   reload_val,
    input  logic [MODE_W-1:0] mode,
    output logic [SIZE-1:0]   count_out,
    output logic              rollover_flag,
    output logic              rollover_pulse,
    output logic              done
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    logic [SIZE-1:0] count_r;
    logic            flag_r;
    logic            pulse_r;
    logic            done_r;

    logic [SIZE-1:0] terminal_s;
    logic [SIZE-1:0] start_s;
    logic [SIZE:0]   step_ext_s;
    logic [SIZE:0]   sum_s;
    logic [SIZE:0]   floor_s;
    logic [SIZE-1:0] diff_s;
    logic            at_term_s;
    logic            advance_s;

    logic [SIZE-1:0] next_count_s;
    logic            next_pulse_s;
    logic            next_done_s;
    logic            next_flag_s;

    // Direction-dependent limits and the widened arithmetic used by the clamps
    always_comb begin
        terminal_s = dir ? reload_val : rollover_val;
        start_s    = dir ? rollover_val : reload_val;
        step_ext_s = (SIZE+1)'(step);
        sum_s      = {1'b0, count_r} + step_ext_s;
        floor_s    = {1'b0, terminal_s} + step_ext_s;
        diff_s     = count_r - step_ext_s[SIZE-1:0];
        at_term_s  = (count_r == terminal_s);
        // A finished one-shot ignores enable until clear or load re-arms it
        advance_s  = count_enable && (step != {STEP_W{1'b0}})
                     && !((mode == MODE_ONESHOT) && done_r);
    end

    // Next-state selection: clear > load > count > hold
    always_comb begin
        next_count_s = count_r;
        next_pulse_s = 1'b0;
        next_done_s  = done_r;
        if (clear) begin
            next_count_s = {SIZE{1'b0}};
            next_done_s  = 1'b0;
        end else if (load) begin
            next_count_s = load_val;
            next_done_s  = 1'b0;
        end else if (advance_s) begin
            if (at_term_s) begin
                case (mode)
                    MODE_SAT: begin
                        next_count_s = terminal_s;
                    end
                    MODE_ONESHOT: begin
                        next_count_s = terminal_s;
                        next_done_s  = 1'b1;
                    end
                    MODE_WRAP, MODE_RSVD: begin
                        next_count_s = start_s;
                        // Degenerate window: wrapping lands back on terminal
                        next_pulse_s = (start_s == terminal_s);
                    end
                    default: begin
                        next_count_s = start_s;
                        next_pulse_s = (start_s == terminal_s);
                    end
                endcase
            end else if (!dir) begin
                if (sum_s >= {1'b0, terminal_s}) begin
                    next_count_s = terminal_s;
                    next_pulse_s = 1'b1;
                end else begin
                    next_count_s = sum_s[SIZE-1:0];
                    next_pulse_s = 1'b0;
                end
            end else begin
                if ({1'b0, count_r} < floor_s) begin
                    next_count_s = terminal_s;
                    next_pulse_s = 1'b1;
                end else begin
                    next_count_s = diff_s;
                    // Exact landing on terminal via subtraction also strobes
                    next_pulse_s = (diff_s == terminal_s);
                end
            end
        end else begin
            next_count_s = count_r;
            next_pulse_s = 1'b0;
        end
        next_flag_s = (next_count_s == terminal_s);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= {SIZE{1'b0}};
            flag_r  <= 1'b0;
            pulse_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            flag_r  <= next_flag_s;
            pulse_r <= next_pulse_s;
            done_r  <= next_done_s;
        end
    end

    assign count_out      = count_r;
    assign rollover_flag  = flag_r;
    assign rollover_pulse = pulse_r;
    assign done           = done_r;

endmodule

// File: tb/tb_usb_tx_flex_counter_v2.sv
// Directed scenarios plus randomized traffic against an arithmetic reference
// model of the multi-mode counter.
module tb_usb_tx_flex_counter_v2;

    localparam int SIZE   = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              clear;
    logic              load;
    logic [SIZE-1:0]   load_val;
    logic              count_enable;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic [SIZE-1:0]   rollover_val;
    logic [SIZE-1:0]   reload_val;
    logic [1:0]        mode;
    logic [SIZE-1:0]   count_out;
    logic              rollover_flag;
    logic              rollover_pulse;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    int m_count = 0;
    int m_done  = 0;
    int m_flag  = 0;
    int m_pulse = 0;

    always #5 clk = ~clk;

    usb_tx_flex_counter_v2 #(.SIZE(SIZE), .STEP_W(STEP_W), .MODE_W(2)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
        .count_enable(count_enable), .dir(dir), .step(step),
        .rollover_val(rollover_val), .reload_val(reload_val), .mode(mode),
        .count_out(count_out), .rollover_flag(rollover_flag),
        .rollover_pulse(rollover_pulse), .done(done)
    );

    task automatic model_reset();
        m_count = 0; m_done = 0; m_flag = 0; m_pulse = 0;
    endtask

    // Reference: up moves toward T as min(c+step,T), down as max(c-step,T)
    task automatic model_step();
        int t, s, c, st, nc, np;
        t  = dir ? int'(reload_val) : int'(rollover_val);
        s  = dir ? int'(rollover_val) : int'(reload_val);
        c  = m_count;
        st = int'(step);
        nc = c;
        np = 0;
        if (clear) begin
            nc = 0; m_done = 0;
        end else if (load) begin
            nc = int'(load_val); m_done = 0;
        end else if (count_enable && st != 0 && !(mode == 2'd2 && m_done == 1)) begin
            if (c == t) begin
                if (mode == 2'd1) nc = t;
                else if (mode == 2'd2) begin nc = t; m_done = 1; end
                else begin nc = s; np = (s == t) ? 1 : 0; end
            end else if (!dir) begin
                nc = (c + st >= t) ? t : c + st;
                np = (nc == t) ? 1 : 0;
            end else begin
                nc = (c - st <= t) ? t : c - st;
                np = (nc == t) ? 1 : 0;
            end
        end
        m_count = nc;
        m_pulse = np;
        m_flag  = (nc == t) ? 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        load_val = 8'd0; dir = 1'b0; step = 4'd1; mode = 2'd0;
        rollover_val = 8'd20; reload_val = 8'd0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (count_out !== 8'd0 || rollover_flag !== 1'b0 || rollover_pulse !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_init: count=%0d flag=%b pulse=%b done=%b, want 0 0 0 0",
                     count_out, rollover_flag, rollover_pulse, done);
        else n_pass++;
        @(posedge clk); #1;
        n_rst = 1'b1;
        count_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (count_out !== 8'd5) $display("FAIL count_to_5: count=%0d, want 5", count_out);
        else n_pass++;
        #2 n_rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (count_out !== 8'd0 || rollover_flag !== 1'b0 || rollover_pulse !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_async: count=%0d flag=%b pulse=%b done=%b, want 0 0 0 0",
                     count_out, rollover_flag, rollover_pulse, done);
        else n_pass++;
        set_idle();
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_wrap_up();
        int exp_v[8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        dir = 1'b0; step = 4'd1; reload_val = 8'd1; rollover_val = 8'd4; mode = 2'd0;
        clear = 1'b1; tick(); clear = 1'b0;
        count_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (count_out !== exp_v[i] || rollover_pulse !== (exp_v[i] == 4) || rollover_flag !== (exp_v[i] == 4))
                $display("FAIL wrap_up[%0d]: count=%0d pulse=%b flag=%b, want count=%0d pulse/flag=%b",
                         i, count_out, rollover_pulse, rollover_flag, exp_v[i], exp_v[i] == 4);
            else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_saturate();
        int exp_v[5] = '{3, 6, 9, 10, 10};
        int exp_p[5] = '{0, 0, 0, 1, 0};
        dir = 1'b0; step = 4'd3; reload_val = 8'd0; rollover_val = 8'd10; mode = 2'd1;
        clear = 1'b1; tick(); clear = 1'b0;
        count_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (count_out !== exp_v[i] || rollover_pulse !== exp_p[i][0] || rollover_flag !== (exp_v[i] == 10))
                $display("FAIL saturate[%0d]: count=%0d pulse=%b flag=%b, want %0d %0d %b",
                         i, count_out, rollover_pulse, rollover_flag, exp_v[i], exp_p[i], exp_v[i] == 10);
            else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_down_oneshot();
        int exp_v[7] = '{5, 3, 1, 0, 0, 0, 0};
        int exp_p[7] = '{0, 0, 0, 1, 0, 0, 0};
        int exp_d[7] = '{0, 0, 0, 0, 1, 1, 1};
        dir = 1'b1; step = 4'd2; rollover_val = 8'd7; reload_val = 8'd0; mode = 2'd2;
        load = 1'b1; load_val = 8'd7; tick(); load = 1'b0;
        n_checks++;
        if (count_out !== 8'd7 || done !== 1'b0 || rollover_flag !== 1'b0)
            $display("FAIL oneshot_load: count=%0d done=%b flag=%b, want 7 0 0", count_out, done, rollover_flag);
        else n_pass++;
        count_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (count_out !== exp_v[i] || rollover_pulse !== exp_p[i][0] || done !== exp_d[i][0]
                || rollover_flag !== (exp_v[i] == 0))
                $display("FAIL oneshot[%0d]: count=%0d pulse=%b done=%b, want %0d %0d %0d",
                         i, count_out, rollover_pulse, done, exp_v[i], exp_p[i], exp_d[i]);
            else n_pass++;
        end
        load = 1'b1; load_val = 8'd7; tick(); load = 1'b0;
        n_checks++;
        if (count_out !== 8'd7 || done !== 1'b0 || rollover_pulse !== 1'b0)
            $display("FAIL oneshot_rearm: count=%0d done=%b pulse=%b, want 7 0 0", count_out, done, rollover_pulse);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_priority();
        dir = 1'b0; step = 4'd1; rollover_val = 8'd9; reload_val = 8'd0; mode = 2'd0;
        load = 1'b1; load_val = 8'd6; tick();
        clear = 1'b1; load = 1'b1; count_enable = 1'b1; load_val = 8'd9; tick();
        n_checks++;
        if (count_out !== 8'd0 || done !== 1'b0 || rollover_pulse !== 1'b0 || rollover_flag !== 1'b0)
            $display("FAIL prio_clear: count=%0d done=%b pulse=%b flag=%b, want 0 0 0 0",
                     count_out, done, rollover_pulse, rollover_flag);
        else n_pass++;
        clear = 1'b0; tick();
        n_checks++;
        if (count_out !== 8'd9 || rollover_flag !== 1'b1 || rollover_pulse !== 1'b0)
            $display("FAIL prio_load_T: count=%0d flag=%b pulse=%b, want 9 1 0",
                     count_out, rollover_flag, rollover_pulse);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_degenerate();
        dir = 1'b0; step = 4'd1; rollover_val = 8'd3; reload_val = 8'd3; mode = 2'd0;
        load = 1'b1; load_val = 8'd3; tick(); load = 1'b0;
        count_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (count_out !== 8'd3 || rollover_pulse !== 1'b1 || rollover_flag !== 1'b1)
                $display("FAIL degenerate[%0d]: count=%0d pulse=%b flag=%b, want 3 1 1",
                         i, count_out, rollover_pulse, rollover_flag);
            else n_pass++;
        end
        mode = 2'd1; rollover_val = 8'd2;
        tick();
        n_checks++;
        if (count_out !== 8'd2 || rollover_pulse !== 1'b1 || rollover_flag !== 1'b1)
            $display("FAIL out_of_range: count=%0d pulse=%b flag=%b, want 2 1 1",
                     count_out, rollover_pulse, rollover_flag);
        else n_pass++;
        tick();
        n_checks++;
        if (count_out !== 8'd2 || rollover_pulse !== 1'b0)
            $display("FAIL out_of_range_hold: count=%0d pulse=%b, want 2 0", count_out, rollover_pulse);
        else n_pass++;
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear        = ($urandom_range(0, 19) == 0);
            load         = ($urandom_range(0, 11) == 0);
            load_val     = 8'($urandom_range(0, 25));
            count_enable = ($urandom_range(0, 3) != 0);
            dir          = 1'($urandom_range(0, 1));
            step         = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
            mode         = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rollover_val = 8'($urandom_range(0, 20));
                reload_val   = 8'($urandom_range(0, 20));
            end
            tick();
            n_checks++;
            if (count_out !== m_count[SIZE-1:0] || rollover_flag !== m_flag[0]
                || rollover_pulse !== m_pulse[0] || done !== m_done[0])
                $display("FAIL random[%0d]: count=%0d flag=%b pulse=%b done=%b, want %0d %0d %0d %0d",
                         i, count_out, rollover_flag, rollover_pulse, done, m_count, m_flag, m_pulse, m_done);
            else n_pass++;
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate();
        test_down_oneshot();
        test_priority();
        test_degenerate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
